fetch_prefetch_queue: RTL

Instruction-fetch front end of the processor. Owns the fetch PC, issues word reads to instruction memory over a request/acknowledge handshake, and buffers returned instructions with their PC+4 in a small FIFO. It feeds the decode stage (`Instr`, `PCPLUS4`) under a valid/ready handshake and accepts branch redirects (`PCSrc`, `BranchAdd`) from the execute/writeback path, flushing stale entries.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_prefetch_queue.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_REQ   = 2'd1,
    F_DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched instructions; flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~flush & ~full;
  assign do_pop  = pop & ~flush & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only observed behind a non-empty count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: owns the PC, reads instruction memory one word at a time,
// and queues {instr, pc+4} for decode. Redirects flush the queue and drop any
// response that belongs to the abandoned stream.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch_cnt / flush_cnt.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        PCSrc,
  input  logic [31:0] BranchAdd,
  output logic [31:0] Instr,
  output logic [31:0] PCPLUS4,
  output logic        instr_valid,
  input  logic        instr_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam logic [31:0] STEP = 32'(WORD_BYTES);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_nxt;
  logic [31:0]   addr_nxt;
  logic [CW-1:0] count;
  logic [CW:0]   cnt_after;
  logic          empty;
  logic          full;
  logic          ack_v;
  logic          push;
  logic          pop;
  fetch_entry_t  wentry;
  fetch_entry_t  head;

  // An ack only counts while a request is actually outstanding.
  assign ack_v     = imem_ack & (state != F_IDLE);
  assign push      = ack_v & (state == F_REQ) & ~PCSrc & ~full;
  assign pop       = instr_valid & instr_ready & ~PCSrc;
  assign cnt_after = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);

  assign wentry.instr   = imem_rdata;
  assign wentry.pcplus4 = fetch_pc + STEP;

  assign instr_valid = ~empty;
  assign Instr       = empty ? 32'h0 : head.instr;
  assign PCPLUS4     = empty ? 32'h0 : head.pcplus4;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (PCSrc),
    .wdata (wentry),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Next state, next fetch PC and next request address.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    addr_nxt     = imem_addr;

    if (PCSrc)     fetch_pc_nxt = BranchAdd & ~32'h3;
    else if (push) fetch_pc_nxt = fetch_pc + STEP;

    case (state)
      F_IDLE: begin
        if (PCSrc || (count < CW'(DEPTH))) state_nxt = F_REQ;
      end
      F_REQ: begin
        if (PCSrc)      state_nxt = ack_v ? F_REQ : F_DRAIN;
        else if (ack_v) state_nxt = (cnt_after < (CW+1)'(DEPTH)) ? F_REQ : F_IDLE;
      end
      F_DRAIN: begin
        if (ack_v) state_nxt = F_REQ;
      end
      default: state_nxt = F_IDLE;
    endcase

    // A draining request keeps its abandoned address until the ack retires it.
    if (state_nxt != F_DRAIN) addr_nxt = fetch_pc_nxt;
  end

  // FSM, fetch PC and registered memory request outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= F_IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      imem_req  <= (state_nxt != F_IDLE);
      imem_addr <= addr_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Delivered-instruction and redirect event counters, free-running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (pop)   fetch_cnt <= fetch_cnt + 32'd1;
      if (PCSrc) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
